fpu_conv_row: RTL and testbench
===============================

FPU_CONV_ROW -- requirements
Module: fpu_conv_row

Interface
REQ-001 Parameter COL_WIDTH, default 10, pixels per input column; output lanes = COL_WIDTH-2; SHALL be >= 3.
REQ-002 Parameter SHIFT_W, default 3, width of the post-sum normaliser shift.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 col_valid  input  1  column offered; col_ready  output  1  column accepted when both high.
REQ-006 col_data  input  [7:0] x COL_WIDTH  unsigned column pixels, index 0 = top row.
REQ-007 col_last  input  1  offered column is the frame's final column.
REQ-008 filt_load  input  1  load pulse; filt_coef  input  signed [7:0] x 9; filt_shift  input  SHIFT_W.
REQ-009 res_valid  output  1; res_ready  input  1; result transferred when both high.
REQ-010 res_pixels  output  [7:0] x (COL_WIDTH-2); res_last  output  1, final result of frame.
REQ-011 busy  output  1  high when state != IDLE or any pipeline stage holds data; frame_short  output  1  one-cycle pulse.

Function
REQ-012 Window = three most recently accepted columns of the current frame: c0 oldest, c1 middle, c2 newest.
REQ-013 Lane j result = sum over r,k in 0..2 of cK[j+r] * filt_coef[3*r+k], k = column age (0 = c0).
REQ-014 Pixel zero-extended to 9 bits signed; product 17-bit signed; 9-term sum 21-bit signed, no overflow possible.
REQ-015 Sum arithmetic-shifted right by registered filt_shift (0..2^SHIFT_W-1) before output conversion.
REQ-016 State machine IDLE, FILL1, FILL2, RUN; each accepted column advances IDLE->FILL1->FILL2->RUN; RUN holds.
REQ-017 Every column accepted in FILL2 or RUN issues one window into the pipeline.
REQ-018 Accepted column with col_last: returns to IDLE next cycle; from RUN its window's result carries res_last=1.
REQ-019 col_last accepted in IDLE, FILL1 or FILL2: no result issued, frame_short pulses the following cycle, state to IDLE.
REQ-020 Pipeline two stages (S1 products, S2 sum/shift/convert into output register); no-stall latency: res_valid rises 2 cycles after the accepting edge.
REQ-021 stall = res_valid & ~res_ready; when stalled, all stages and window hold; col_ready = ~stall.
REQ-022 res_pixels and res_last SHALL remain stable while res_valid & ~res_ready.
REQ-023 Full throughput: one result per cycle when col_valid and res_ready held high in RUN.
REQ-024 filt_load honoured only when busy=0 (coef/shift captured next edge); otherwise ignored with no effect.
REQ-025 filt_load and col_valid in the same IDLE cycle: filter captured first; that column uses the new coefficients from S1 onward.

Reset
REQ-026 rst_n low: state IDLE, window cleared, pipeline valids 0, res_valid 0, res_last 0, res_pixels 0, frame_short 0, busy 0.
REQ-027 Coefficients reset to 0, shift to 0; reset mid-frame discards all in-flight windows with no result emitted.
REQ-028 col_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-029 Macro FPU_CONV_SAT_EN defined: shifted sum clamped to 0..255 (negative -> 0, >255 -> 255).
REQ-030 FPU_CONV_SAT_EN undefined: output = low 8 bits of shifted sum (two's-complement wrap).

Structure
REQ-031 Package fpu_conv_pkg holds PIXEL_W=8, COEF_W=8, PROD_W=17, ACC_W=21, the state enum, and the sat/wrap conversion function.
REQ-032 Sub-module conv_lane: one 3x3 two-stage MAC lane with enable; instantiated COL_WIDTH-2 times by generate.

Verification
REQ-033 All coef 1, shift 0, three columns of all 10 -> res_pixels all 90 at cycle t+2 after third accept, res_last per col_last.
REQ-034 Coef {-1,0,1,-2,0,2,-1,0,1}, columns 0,0,255 -> lanes 1020 >> shift 2 = 255; sat build 255, wrap build 255; shift 0 -> sat 255, wrap 8'hFC.
REQ-035 Columns 255,255,0 with REQ-034 coefs -> sum -1020: sat build 0, wrap build low byte of sum after shift.
REQ-036 res_ready low for 5 cycles mid-stream -> col_ready low, outputs frozen, no result lost or duplicated, order preserved.
REQ-037 Frame of 2 columns ending col_last -> no res_valid, frame_short pulse, state IDLE; next frame starts fresh at FILL1.
REQ-038 filt_load while busy -> ignored (results use old coefs); rst_n asserted mid-frame -> all outputs to reset values immediately.

Source files
------------

// File: rtl/fpu_conv_pkg.sv
// Shared widths, FSM state type and output conversion for the row convolver.
// FPU_CONV_SAT_EN selects clamping to 0..255 instead of two's-complement wrap.
package fpu_conv_pkg;

  localparam int PIXEL_W = 8;
  localparam int COEF_W  = 8;
  localparam int PROD_W  = 17;
  localparam int ACC_W   = 21;

`ifdef FPU_CONV_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL1,
    ST_FILL2,
    ST_RUN
  } state_t;

  function automatic logic [PIXEL_W-1:0] conv_pixel(input logic signed [ACC_W-1:0] v);
    if (SAT_EN && v[ACC_W-1]) return '0;
    if (SAT_EN && (|v[ACC_W-2:PIXEL_W])) return '1;
    return v[PIXEL_W-1:0];
  endfunction

endpackage

// File: rtl/conv_lane.sv
// One 3x3 MAC lane: S1 registers nine products, S2 sums, shifts, converts.
// Latency 2 enabled cycles; each stage holds while its enable is low.
module conv_lane
  import fpu_conv_pkg::*;
#(
  parameter int SHIFT_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s1_en,
  input  logic                    s2_en,
  input  logic [8:0][PIXEL_W-1:0] win,
  input  logic [8:0][COEF_W-1:0]  coef,
  input  logic [SHIFT_W-1:0]      shift,
  output logic [PIXEL_W-1:0]      pixel
);

  logic signed [PROD_W-1:0] prod_d [9];
  logic signed [PROD_W-1:0] prod_q [9];
  logic signed [ACC_W-1:0]  sum;

  // Pixels are unsigned, so zero-extend before the signed multiply.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      prod_d[i] = $signed({{(PROD_W-PIXEL_W){1'b0}}, win[i]}) *
                  $signed({{(PROD_W-COEF_W){coef[i][COEF_W-1]}}, coef[i]});
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) begin
      sum = sum + ACC_W'(prod_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      pixel <= '0;
    end else begin
      if (s1_en) begin
        for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
      end
      if (s2_en) pixel <= conv_pixel(sum >>> shift);
    end
  end

endmodule

// File: rtl/fpu_conv_row.sv
// Column-streaming 3x3 convolver producing COL_WIDTH-2 pixels per accepted column.
// Result 2 cycles after the issuing column; res_ready low freezes all stages and drops col_ready.
// FPU_CONV_SAT_EN: clamp outputs to 0..255, otherwise wrap to the low byte.
module fpu_conv_row
  import fpu_conv_pkg::*;
#(
  parameter int COL_WIDTH = 10,
  parameter int SHIFT_W   = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                col_valid,
  output logic                                col_ready,
  input  logic [COL_WIDTH-1:0][PIXEL_W-1:0]   col_data,
  input  logic                                col_last,
  input  logic                                filt_load,
  input  logic [8:0][COEF_W-1:0]              filt_coef,
  input  logic [SHIFT_W-1:0]                  filt_shift,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [COL_WIDTH-3:0][PIXEL_W-1:0]   res_pixels,
  output logic                                res_last,
  output logic                                busy,
  output logic                                frame_short
);

  localparam int LANES = COL_WIDTH - 2;

  state_t state_q, state_d;
  logic [COL_WIDTH-1:0][PIXEL_W-1:0] c0_q, c1_q, c2_q;
  logic [8:0][COEF_W-1:0]            coef_q;
  logic [SHIFT_W-1:0]                shift_q;
  logic w_vld_q, w_last_q, s1_vld_q, s1_last_q;
  logic stall, accept, issue, short_d;

  assign stall     = res_valid & ~res_ready;
  assign col_ready = ~stall;
  assign accept    = col_valid & col_ready;
  assign busy      = (state_q != ST_IDLE) | w_vld_q | s1_vld_q | res_valid;

  // A frame ending before its third column never forms a window.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    short_d = 1'b0;
    if (accept) begin
      case (state_q)
        ST_IDLE:  state_d = ST_FILL1;
        ST_FILL1: state_d = ST_FILL2;
        ST_FILL2: begin
          state_d = ST_RUN;
          issue   = ~col_last;
        end
        default: begin
          state_d = ST_RUN;
          issue   = 1'b1;
        end
      endcase
      if (col_last) begin
        state_d = ST_IDLE;
        short_d = (state_q != ST_RUN);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      c0_q        <= '0;
      c1_q        <= '0;
      c2_q        <= '0;
      coef_q      <= '0;
      shift_q     <= '0;
      w_vld_q     <= 1'b0;
      w_last_q    <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      res_valid   <= 1'b0;
      res_last    <= 1'b0;
      frame_short <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_short <= short_d;
      if (filt_load && !busy) begin
        coef_q  <= filt_coef;
        shift_q <= filt_shift;
      end
      if (accept) begin
        c0_q <= c1_q;
        c1_q <= c2_q;
        c2_q <= col_data;
      end
      if (!stall) begin
        w_vld_q   <= issue;
        w_last_q  <= issue & col_last;
        s1_vld_q  <= w_vld_q;
        s1_last_q <= w_last_q;
        res_valid <= s1_vld_q;
        res_last  <= s1_last_q;
      end
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [8:0][PIXEL_W-1:0] win;
    // Tap 3*r+k holds row j+r of the column aged k (k=0 oldest).
    assign win = {c2_q[j+2], c1_q[j+2], c0_q[j+2],
                  c2_q[j+1], c1_q[j+1], c0_q[j+1],
                  c2_q[j],   c1_q[j],   c0_q[j]};

    conv_lane #(.SHIFT_W(SHIFT_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .s1_en (~stall & w_vld_q),
      .s2_en (~stall & s1_vld_q),
      .win   (win),
      .coef  (coef_q),
      .shift (shift_q),
      .pixel (res_pixels[j])
    );
  end

endmodule

// File: tb/tb_fpu_conv_row.sv
// Directed and randomized checks of fpu_conv_row against a column-window reference model.
module tb_fpu_conv_row;

  localparam int COL_WIDTH = 10;
  localparam int SHIFT_W   = 3;
  localparam int L         = COL_WIDTH - 2;
`ifdef FPU_CONV_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic col_valid, col_ready, col_last, filt_load, res_valid, res_ready, res_last, busy, frame_short;
  logic [COL_WIDTH-1:0][7:0] col_data;
  logic [8:0][7:0]           filt_coef;
  logic [SHIFT_W-1:0]        filt_shift;
  logic [L-1:0][7:0]         res_pixels;

  fpu_conv_row #(.COL_WIDTH(COL_WIDTH), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .rst_n(rst_n), .col_valid(col_valid), .col_ready(col_ready),
    .col_data(col_data), .col_last(col_last), .filt_load(filt_load),
    .filt_coef(filt_coef), .filt_shift(filt_shift), .res_valid(res_valid),
    .res_ready(res_ready), .res_pixels(res_pixels), .res_last(res_last),
    .busy(busy), .frame_short(frame_short)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] pix;
    logic         last;
  } exp_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_coef [9];
  int   m_shift;
  int   win [3][COL_WIDTH];
  int   fcount;
  exp_t exp_q [$];

  logic [8:0][7:0] ones  = {9{8'd1}};
  logic [8:0][7:0] sobel = {8'd1, 8'd0, 8'hFF, 8'd2, 8'd0, 8'hFE, 8'd1, 8'd0, 8'hFF};

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [255:0] rep(input logic [7:0] v);
    logic [255:0] r;
    r = '0;
    for (int j = 0; j < L; j++) r[8*j +: 8] = v;
    return r;
  endfunction

  // Direct evaluation of the 3x3 sum for every lane over the current window.
  function automatic logic [255:0] model_result();
    logic [255:0] r;
    int s;
    r = '0;
    for (int j = 0; j < L; j++) begin
      s = 0;
      for (int rr = 0; rr < 3; rr++)
        for (int k = 0; k < 3; k++)
          s += win[k][j+rr] * m_coef[3*rr+k];
      s = s >>> m_shift;
      if (SAT && s < 0) s = 0;
      if (SAT && s > 255) s = 255;
      r[8*j +: 8] = 8'(s & 255);
    end
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    fcount  = 0;
    m_shift = 0;
    for (int i = 0; i < 9; i++) m_coef[i] = 0;
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < COL_WIDTH; c++) win[k][c] = 0;
  endtask

  // One clock: observe handshakes mid-cycle, update the model, then check post-edge outputs.
  task automatic cycle();
    logic acc, xfer, mbusy, short_now;
    exp_t e;
    #4;
    mbusy = (fcount != 0) || (exp_q.size() != 0);
    if (filt_load && !mbusy) begin
      for (int i = 0; i < 9; i++) m_coef[i] = int'($signed(filt_coef[i]));
      m_shift = int'(filt_shift);
    end
    acc  = col_valid && col_ready;
    xfer = res_valid && res_ready;
    if (res_valid) begin
      if (exp_q.size() == 0) check("res_valid_unexpected", 256'(res_valid), 256'(0));
      else begin
        check("res_pixels", 256'(res_pixels), exp_q[0].pix);
        check("res_last", 256'(res_last), 256'(exp_q[0].last));
        if (xfer) void'(exp_q.pop_front());
      end
    end
    short_now = 1'b0;
    if (acc) begin
      for (int c = 0; c < COL_WIDTH; c++) begin
        win[0][c] = win[1][c];
        win[1][c] = win[2][c];
        win[2][c] = int'(col_data[c]);
      end
      if (fcount >= 3 || (fcount == 2 && !col_last)) begin
        e.pix  = model_result();
        e.last = col_last && (fcount >= 3);
        exp_q.push_back(e);
      end
      short_now = col_last && (fcount < 3);
      fcount    = col_last ? 0 : fcount + 1;
    end
    @(posedge clk);
    #1;
    check("frame_short", 256'(frame_short), 256'(short_now));
    check("busy", 256'(busy), 256'((fcount != 0) || (exp_q.size() != 0)));
  endtask

  task automatic col_const(input logic [7:0] v, input logic last);
    col_valid = 1'b1;
    col_last  = last;
    for (int c = 0; c < COL_WIDTH; c++) col_data[c] = v;
    cycle();
    col_valid = 1'b0;
    col_last  = 1'b0;
  endtask

  task automatic load_filter(input logic [8:0][7:0] cf, input logic [SHIFT_W-1:0] sh);
    filt_load  = 1'b1;
    filt_coef  = cf;
    filt_shift = sh;
    cycle();
    filt_load = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    col_valid = 1'b0;
    col_last  = 1'b0;
    filt_load = 1'b0;
    res_ready = 1'b1;
    while (exp_q.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    check("drain_empty", 256'(exp_q.size()), 256'(0));
    cycle();
  endtask

  // Three columns, check the first result exactly two cycles later, then close the frame.
  task automatic frame3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] expv);
    col_const(a, 1'b0);
    col_const(b, 1'b0);
    col_const(c, 1'b0);
    cycle();
    check("latency_early", 256'(res_valid), 256'(0));
    cycle();
    check("latency_valid", 256'(res_valid), 256'(1));
    check("lanes", 256'(res_pixels), rep(expv));
    check("lanes_last", 256'(res_last), 256'(0));
    col_const(c, 1'b1);
    drain();
  endtask

  initial begin
    col_valid = 1'b0; col_last = 1'b0; filt_load = 1'b0; res_ready = 1'b1;
    col_data = '0; filt_coef = '0; filt_shift = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_res_valid", 256'(res_valid), 256'(0));
    check("rst_res_last", 256'(res_last), 256'(0));
    check("rst_res_pixels", 256'(res_pixels), 256'(0));
    check("rst_frame_short", 256'(frame_short), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("col_ready_after_reset", 256'(col_ready), 256'(1));

    load_filter(ones, 3'd0);
    frame3(8'd10, 8'd10, 8'd10, 8'd90);

    load_filter(sobel, 3'd2);
    frame3(8'd0, 8'd0, 8'd255, 8'd255);
    load_filter(sobel, 3'd0);
    frame3(8'd0, 8'd0, 8'd255, SAT ? 8'd255 : 8'hFC);
    load_filter(sobel, 3'd2);
    frame3(8'd255, 8'd255, 8'd0, SAT ? 8'd0 : 8'd1);

    // Two-column frame: no result, short pulse, then a fresh frame.
    col_const(8'd5, 1'b0);
    col_const(8'd5, 1'b1);
    cycle();
    check("short_idle_busy", 256'(busy), 256'(0));
    frame3(8'd7, 8'd7, 8'd7, 8'd0);

    // Filter load together with the first column of a frame.
    filt_load = 1'b1; filt_coef = ones; filt_shift = 3'd0;
    col_const(8'd10, 1'b0);
    filt_load = 1'b0;
    col_const(8'd10, 1'b0);
    col_const(8'd10, 1'b0);
    cycle();
    cycle();
    check("load_with_col", 256'(res_pixels), rep(8'd90));
    col_const(8'd10, 1'b1);
    drain();

    // Filter load while busy must be ignored.
    col_const(8'd10, 1'b0);
    filt_load = 1'b1; filt_coef = sobel; filt_shift = 3'd2;
    col_const(8'd20, 1'b0);
    filt_load = 1'b0;
    col_const(8'd30, 1'b0);
    cycle();
    cycle();
    check("load_while_busy", 256'(res_pixels), rep(8'd180));
    col_const(8'd30, 1'b1);
    drain();

    // Backpressure: five cycles of res_ready low mid-stream.
    col_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < COL_WIDTH; c++) col_data[c] = 8'($urandom);
      cycle();
    end
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < COL_WIDTH; c++) col_data[c] = 8'($urandom);
      cycle();
      check("stall_col_ready", 256'(col_ready), 256'(0));
      check("stall_res_valid", 256'(res_valid), 256'(1));
    end
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < COL_WIDTH; c++) col_data[c] = 8'($urandom);
      cycle();
    end
    col_last = 1'b1;
    cycle();
    drain();

    for (int i = 0; i < 400; i++) begin
      col_valid  = ($urandom_range(0, 9) < 8);
      res_ready  = ($urandom_range(0, 9) < 7);
      col_last   = ($urandom_range(0, 11) == 0);
      filt_load  = ($urandom_range(0, 7) == 0);
      filt_shift = SHIFT_W'($urandom);
      for (int c = 0; c < COL_WIDTH; c++) col_data[c] = 8'($urandom);
      for (int k = 0; k < 9; k++) filt_coef[k] = 8'($urandom);
      cycle();
    end
    drain();

    // Reset mid-frame with windows in flight.
    col_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < COL_WIDTH; c++) col_data[c] = 8'($urandom);
      cycle();
    end
    col_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_res_valid", 256'(res_valid), 256'(0));
    check("midrst_res_pixels", 256'(res_pixels), 256'(0));
    check("midrst_res_last", 256'(res_last), 256'(0));
    check("midrst_busy", 256'(busy), 256'(0));
    check("midrst_frame_short", 256'(frame_short), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_col_ready", 256'(col_ready), 256'(1));
    frame3(8'd7, 8'd8, 8'd9, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
